rfa_wb_queue: RTL and testbench
===============================

Name: rfa_wb_queue

Overview:
- Per-functional-unit writeback request queue; requester side of the register-file-access arbiter.
- One instance sits in each SIMD/SIMF unit between the ALU pipeline tail and the arbiter.
- Buffers completed results and raises queue_entry_valid. Holds the head entry stable until the arbiter pulses queue_entry_serviced, then pops.
- Presents head-entry fields to the VGPR/SGPR write mux.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- ADDR_WIDTH, 10, destination register address width.
- DATA_WIDTH, 2048, write data width (64 lanes x 32 bits).
- MASK_WIDTH, 64, lane write-enable mask width.
- WFID_WIDTH, 6, wavefront id width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- push_en  input  1  ALU result ready to enqueue this cycle.
- push_addr  input  ADDR_WIDTH  destination register address.
- push_data  input  DATA_WIDTH  result data.
- push_mask  input  MASK_WIDTH  lane write mask.
- push_wfid  input  WFID_WIDTH  wavefront id.
- push_is_sgpr  input  1  1 = SGPR destination, 0 = VGPR.
- queue_entry_serviced  input  1  arbiter grant; head consumed this cycle.
- queue_entry_valid  output  1  head entry present; request to arbiter.
- head_addr  output  ADDR_WIDTH  head destination address.
- head_data  output  DATA_WIDTH  head data.
- head_mask  output  MASK_WIDTH  head lane mask.
- head_wfid  output  WFID_WIDTH  head wavefront id.
- head_is_sgpr  output  1  head destination type.
- queue_full  output  1  count == DEPTH.
- queue_almost_full  output  1  count >= DEPTH-1; the ALU uses it to stall issue.
- entry_count  output  $clog2(DEPTH)+1  occupancy.
- overflow_err  output  1  sticky: push attempted while full and not popping.
- underflow_err  output  1  sticky: serviced seen while queue empty.

Behaviour:
- Storage: circular buffer with rd_ptr and wr_ptr of $clog2(DEPTH) bits each, plus an explicit count register. Pointers wrap modulo DEPTH.
- Reset: takes effect at the clock edge with rst high. It clears rd_ptr, wr_ptr, count, overflow_err and underflow_err.
  - Outputs after reset: queue_entry_valid=0, queue_full=0, queue_almost_full=0, entry_count=0.
  - head_* fields are don't-care while valid=0; the bench must not check them.
  - Reset mid-operation discards all entries. A serviced pulse in the same cycle as rst is ignored.
- pop = queue_entry_serviced & queue_entry_valid.
- push_ok = push_en & (~queue_full | pop).
- Count update: count_next = count + push_ok - pop.
- Latency: a push into an empty queue makes queue_entry_valid=1 on the next cycle, with head_* equal to the pushed values.
- Handshake: while valid=1 and not serviced, head_* and valid hold stable every cycle. After a pop, the next entry (if any) appears the following cycle with valid still 1, so back-to-back grants drain one entry per cycle.
- Push and pop together:
  - Count is unchanged.
  - Allowed even when full: the freed slot is written at wr_ptr.
  - When count==1, the new entry becomes head the next cycle.
- Push while full without pop: data is dropped, pointers and count are unchanged, and overflow_err sets. It stays set until rst.
- Serviced while empty: ignored, and underflow_err sets (sticky).
- Ordering is strict FIFO; entries are never reordered or merged.
- queue_full and queue_almost_full are decoded from the registered count. They reflect the state after the previous edge.

Optional Feature:
- Macro: RFA_WB_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and push_en=1, queue_entry_valid asserts combinationally in the same cycle, with head_* driven from the push_* inputs.
  - If queue_entry_serviced=1 in that cycle, the entry is consumed without being written to storage. Count stays 0 and no sticky error sets.
  - Otherwise the entry is stored normally.
- Not defined: all outputs come from registered state, with the 1-cycle latency described above.

Test Plan:
- Reset then idle: rst high 2 cycles, then low -> queue_entry_valid=0, entry_count=0, both error flags 0.
- Single entry: push addr=0x01A, mask=all-ones, wfid=5 with no serviced -> next cycle valid=1 and head_addr=0x01A. Hold unserviced 3 cycles -> fields stable. Pulse serviced -> next cycle valid=0, count=0.
- Fill and wrap (DEPTH=4): push addresses 1..4 -> queue_full=1, count=4. Push 5 with no serviced -> overflow_err=1, count stays 4. Then push 6 together with serviced on head 1 -> count=4. Drain with serviced every cycle -> head sequence 2,3,4,6.
- Almost-full: push 3 entries -> queue_almost_full=1, queue_full=0. Pop 1 -> queue_almost_full=0.
- Underflow and reset mid-operation: serviced with queue empty -> underflow_err=1. Push 2 entries, assert rst -> next cycle count=0, valid=0, both errors cleared.
- Bypass with macro defined: empty queue, push addr=0x3FF and serviced in the same cycle -> valid=1 and head_addr=0x3FF that cycle, count=0 the next cycle. Without the macro: valid=0 that cycle, serviced ignored, underflow_err=1, and valid=1 the next cycle.

Source files
------------

// File: rtl/rfa_wb_queue.sv
// rfa_wb_queue: per-functional-unit writeback request queue feeding the
// register-file-access arbiter. Circular buffer with an explicit occupancy
// count. The head entry is held stable until the arbiter pulses
// queue_entry_serviced.
//
// Optional feature macro: RFA_WB_QUEUE_BYPASS_EN
//   When it is defined, a push into an empty queue is presented at the head
//   combinationally in the same cycle. If that entry is serviced in the same
//   cycle, it is consumed without being written to storage.
//   When it is undefined, the head comes from registered state with a
//   one-cycle push-to-valid latency.
module rfa_wb_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 2048,
  parameter int unsigned MASK_WIDTH = 64,
  parameter int unsigned WFID_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_en,
  input  logic [ADDR_WIDTH-1:0]   push_addr,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic [MASK_WIDTH-1:0]   push_mask,
  input  logic [WFID_WIDTH-1:0]   push_wfid,
  input  logic                    push_is_sgpr,
  input  logic                    queue_entry_serviced,
  output logic                    queue_entry_valid,
  output logic [ADDR_WIDTH-1:0]   head_addr,
  output logic [DATA_WIDTH-1:0]   head_data,
  output logic [MASK_WIDTH-1:0]   head_mask,
  output logic [WFID_WIDTH-1:0]   head_wfid,
  output logic                    head_is_sgpr,
  output logic                    queue_full,
  output logic                    queue_almost_full,
  output logic [$clog2(DEPTH):0]  entry_count,
  output logic                    overflow_err,
  output logic                    underflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ALMOST_CNT = CNT_W'(DEPTH - 1);

  // Entry storage, one array per field
  logic [ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
  logic [MASK_WIDTH-1:0] r_mask_mem [DEPTH];
  logic [WFID_WIDTH-1:0] r_wfid_mem [DEPTH];
  logic                  r_sgpr_mem [DEPTH];

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_byp_active;
  logic             w_byp_consume;
  logic             w_valid;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_store;
  logic             w_pop_mem;
  logic [CNT_W-1:0] w_count_next;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

`ifdef RFA_WB_QUEUE_BYPASS_EN
  assign w_byp_active = w_empty & push_en;
`else
  assign w_byp_active = 1'b0;
`endif

  // A bypassed entry that is serviced in its push cycle never touches storage
  assign w_byp_consume = w_byp_active & queue_entry_serviced;
  assign w_valid       = ~w_empty | w_byp_active;
  assign w_pop         = queue_entry_serviced & w_valid;
  assign w_push_ok     = push_en & (~w_full | w_pop);
  assign w_store       = w_push_ok & ~w_byp_consume;
  assign w_pop_mem     = w_pop & ~w_byp_consume;
  assign w_count_next  = r_count + CNT_W'(w_store) - CNT_W'(w_pop_mem);

  // Write accepted entries at the write pointer
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_addr_mem[r_wr_ptr] <= push_addr;
      r_data_mem[r_wr_ptr] <= push_data;
      r_mask_mem[r_wr_ptr] <= push_mask;
      r_wfid_mem[r_wr_ptr] <= push_wfid;
      r_sgpr_mem[r_wr_ptr] <= push_is_sgpr;
    end
  end

  // Pointer, occupancy and sticky error state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_mem) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;
      if (push_en & w_full & ~w_pop) begin
        r_overflow <= 1'b1;
      end
      if (queue_entry_serviced & ~w_valid) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Head presentation: bypass path from the push inputs, else the storage head
  always_comb begin
    head_addr    = r_addr_mem[r_rd_ptr];
    head_data    = r_data_mem[r_rd_ptr];
    head_mask    = r_mask_mem[r_rd_ptr];
    head_wfid    = r_wfid_mem[r_rd_ptr];
    head_is_sgpr = r_sgpr_mem[r_rd_ptr];
    if (w_byp_active) begin
      head_addr    = push_addr;
      head_data    = push_data;
      head_mask    = push_mask;
      head_wfid    = push_wfid;
      head_is_sgpr = push_is_sgpr;
    end
  end

  assign queue_entry_valid = w_valid;
  assign queue_full        = w_full;
  assign queue_almost_full = (r_count >= ALMOST_CNT);
  assign entry_count       = r_count;
  assign overflow_err      = r_overflow;
  assign underflow_err     = r_underflow;

endmodule

// File: tb/tb_rfa_wb_queue.sv
// Testbench for rfa_wb_queue: directed steps with a scoreboard of pushed entries.
// Honours RFA_WB_QUEUE_BYPASS_EN when it is defined for the build.
module tb_rfa_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 2048;
  localparam int unsigned MW    = 64;
  localparam int unsigned WW    = 6;
`ifdef RFA_WB_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    logic [WW-1:0] wfid;
    logic          sgpr;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_en;
  logic [AW-1:0] push_addr;
  logic [DW-1:0] push_data;
  logic [MW-1:0] push_mask;
  logic [WW-1:0] push_wfid;
  logic          push_is_sgpr;
  logic          queue_entry_serviced;
  logic          queue_entry_valid;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [MW-1:0] head_mask;
  logic [WW-1:0] head_wfid;
  logic          head_is_sgpr;
  logic          queue_full;
  logic          queue_almost_full;
  logic [$clog2(DEPTH):0] entry_count;
  logic          overflow_err;
  logic          underflow_err;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  ent_t sb[$];
  bit   m_ovf = 1'b0;
  bit   m_udf = 1'b0;

  always #5 clk = ~clk;

  rfa_wb_queue #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .WFID_WIDTH(WW)
  ) dut (
    .clk(clk), .rst(rst),
    .push_en(push_en), .push_addr(push_addr), .push_data(push_data),
    .push_mask(push_mask), .push_wfid(push_wfid), .push_is_sgpr(push_is_sgpr),
    .queue_entry_serviced(queue_entry_serviced),
    .queue_entry_valid(queue_entry_valid),
    .head_addr(head_addr), .head_data(head_data), .head_mask(head_mask),
    .head_wfid(head_wfid), .head_is_sgpr(head_is_sgpr),
    .queue_full(queue_full), .queue_almost_full(queue_almost_full),
    .entry_count(entry_count),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    logic [31:0]   w;
    w = 32'hA5C3_0000 ^ {22'd0, a};
    for (int i = 0; i < 64; i++) d[i*32 +: 32] = w + 32'(i * 7);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed[63:0]=%0h expected[63:0]=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic chk_head(input ent_t e);
    chk("head_addr", 64'(head_addr), 64'(e.addr));
    chk_data("head_data", head_data, e.data);
    chk("head_mask", 64'(head_mask), 64'(e.mask));
    chk("head_wfid", 64'(head_wfid), 64'(e.wfid));
    chk("head_is_sgpr", 64'(head_is_sgpr), 64'(e.sgpr));
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance
  task automatic cyc(input bit pe, input logic [AW-1:0] a, input logic [MW-1:0] m,
                     input logic [WW-1:0] w, input bit s, input bit serv);
    ent_t e;
    int unsigned cnt;
    bit vld, pop, full, byp;
    push_en = pe; push_addr = a; push_data = mk_data(a); push_mask = m;
    push_wfid = w; push_is_sgpr = s; queue_entry_serviced = serv;
    e.addr = a; e.data = mk_data(a); e.mask = m; e.wfid = w; e.sgpr = s;
    #1;
    cnt  = sb.size();
    byp  = BYP && cnt == 0 && pe;
    vld  = (cnt != 0) || byp;
    full = (cnt == DEPTH);
    chk("valid", 64'(queue_entry_valid), 64'(vld));
    chk("entry_count", 64'(entry_count), 64'(cnt));
    chk("queue_full", 64'(queue_full), 64'(full));
    chk("almost_full", 64'(queue_almost_full), 64'(cnt >= DEPTH - 1));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    chk("underflow_err", 64'(underflow_err), 64'(m_udf));
    if (vld) chk_head(byp ? e : sb[0]);
    pop = serv && vld;
    if (pe && full && !pop) m_ovf = 1'b1;
    if (serv && !vld) m_udf = 1'b1;
    if (pop && !byp) void'(sb.pop_front());
    if (pe && (!full || pop) && !(byp && pop)) sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [AW-1:0] a, input bit serv);
    cyc(1'b1, a, {32'h0F0F_0F0F, 22'd0, a}, WW'(a), a[0], serv);
  endtask

  task automatic srv();
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic do_reset(input int unsigned n, input bit serv);
    rst = 1'b1; push_en = 1'b0; queue_entry_serviced = serv;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0; queue_entry_serviced = 1'b0;
    sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  initial begin
    rst = 1'b1; push_en = 1'b0; push_addr = '0; push_data = '0; push_mask = '0;
    push_wfid = '0; push_is_sgpr = 1'b0; queue_entry_serviced = 1'b0;

    // Reset then idle
    do_reset(2, 1'b0);
    idle(2);

    // Single entry held unserviced, then popped
    cyc(1'b1, 10'h01A, '1, 6'd5, 1'b0, 1'b0);
    #0 chk("single_head_addr", 64'(head_addr), 64'h01A);
    idle(3);
    srv();
    idle(1);
    chk("single_drained_count", 64'(entry_count), 64'd0);

    // Fill, overflow, push+pop while full, drain with back-to-back grants
    for (int unsigned i = 1; i <= 4; i++) push(AW'(i), 1'b0);
    chk("fill_full", 64'(queue_full), 64'd1);
    push(10'd5, 1'b0);
    chk("ovf_set", 64'(overflow_err), 64'd1);
    chk("ovf_count", 64'(entry_count), 64'd4);
    push(10'd6, 1'b1);
    chk("pushpop_count", 64'(entry_count), 64'd4);
    for (int unsigned i = 0; i < 4; i++) srv();
    idle(1);

    // Almost-full
    for (int unsigned i = 7; i <= 9; i++) push(AW'(i), 1'b0);
    chk("almost_full_set", 64'(queue_almost_full), 64'd1);
    srv();
    chk("almost_full_clr", 64'(queue_almost_full), 64'd0);
    srv();
    // count==1: push with pop makes the new entry head next cycle
    push(10'd10, 1'b1);
    chk("cnt1_pushpop_head", 64'(head_addr), 64'd10);
    srv();
    idle(1);

    // Underflow, then reset mid-operation with a concurrent serviced pulse
    srv();
    chk("udf_set", 64'(underflow_err), 64'd1);
    push(10'h011, 1'b0);
    push(10'h012, 1'b0);
    do_reset(1, 1'b1);
    idle(1);
    chk("rst_mid_count", 64'(entry_count), 64'd0);
    chk("rst_mid_ovf", 64'(overflow_err), 64'd0);

    // Bypass behaviour (or its absence) on an empty queue
    push(10'h3FF, 1'b1);
    idle(1);
    srv();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
